// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed by a small valid/ready FIFO.
// Frames are sent back-to-back while the FIFO holds data; tx comes straight from a flop.
module uart_tx #(
    parameter int clks_per_bit    = 868,
    parameter int fifo_depth_log2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy
);

    localparam int depth = 1 << fifo_depth_log2;
    localparam int ptr_w = fifo_depth_log2;
    localparam int cnt_w = $clog2(clks_per_bit);

    localparam logic [ptr_w:0]   full_level = (ptr_w + 1)'(depth);
    localparam logic [cnt_w-1:0] last_tick  = cnt_w'(clks_per_bit - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [ptr_w:0]   count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full       = (count == full_level);
    assign empty      = (count == '0);
    assign data_ready = !full;
    assign push       = data_valid && !full;

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are live, so clearing the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [cnt_w-1:0] clk_cnt;
    logic [cnt_w-1:0] clk_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             tx_next;
    logic             bit_done;

    assign bit_done = (clk_cnt == last_tick);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    // tx_next is the value tx takes in the first clock of the next state,
    // which is what gives the one-clock accept-to-start latency.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and infers a latch.
        state_next   = state;
        clk_cnt_next = clk_cnt + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        tx_next      = tx;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                clk_cnt_next = '0;
                tx_next      = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end

            START: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                    tx_next      = shift[0];
                end
            end

            DATA: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift_next   = shift >> 1;
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift[1];
                    end
                end
            end

            STOP: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end

            default: begin
                clk_cnt_next = '0;
                state_next   = IDLE;
                tx_next      = 1'b1;
            end
        endcase
    end

    assign busy = (state != IDLE) || !empty;

endmodule
